// File: rtl/brdg_context_receiver.sv
// TLX-side receiver for the AFU->TLX command stream: absorbs assign_actag into an
// acTag->PASID table, checks every other command against it and queues it in a FWFT FIFO.
module brdg_context_receiver #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        afu_tlx_cmd_valid,
    input  logic [7:0]  afu_tlx_cmd_opcode,
    input  logic [15:0] afu_tlx_cmd_afutag,
    input  logic [67:0] afu_tlx_cmd_ea_or_obj,
    input  logic [1:0]  afu_tlx_cmd_dl,
    input  logic [2:0]  afu_tlx_cmd_pl,
    input  logic [11:0] afu_tlx_cmd_actag,
    input  logic [19:0] afu_tlx_cmd_pasid,
    output logic        tlx_afu_cmd_ready,
    output logic        out_cmd_valid,
    input  logic        out_cmd_ready,
    output logic [7:0]  out_cmd_opcode,
    output logic [15:0] out_cmd_afutag,
    output logic [67:0] out_cmd_ea_or_obj,
    output logic [1:0]  out_cmd_dl,
    output logic [2:0]  out_cmd_pl,
    output logic [19:0] out_cmd_pasid,
    output logic [5:0]  out_cmd_actag,
    output logic [1:0]  out_cmd_err,
    input  logic        err_clear,
    output logic [2:0]  err_sticky,
    output logic [5:0]  err_actag
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0]    OP_ASSIGN = 8'h50;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW:0]   READY_LIM = (CW + 1)'(DEPTH - 2);

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] afutag;
        logic [67:0] ea_or_obj;
        logic [1:0]  dl;
        logic [2:0]  pl;
        logic [19:0] pasid;
        logic [5:0]  actag;
        logic [1:0]  err;
    } cmd_t;

    logic          r_s1_valid;
    cmd_t          r_s1_cmd;
    logic [63:0]   r_tbl_vld;
    logic [19:0]   r_tbl_pasid [0:63];
    cmd_t          r_mem [0:DEPTH-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ready;
    logic [2:0]    r_err_sticky;
    logic [5:0]    r_err_actag;

    cmd_t          w_in_cmd;
    cmd_t          w_push_cmd;
    cmd_t          w_head;
    logic          w_is_assign;
    logic          w_is_cmd;
    logic          w_ent_vld;
    logic [19:0]   w_ent_pasid;
    logic [1:0]    w_err;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf;
    logic [CW:0]   w_occ;
    logic [2:0]    w_sticky_base;
    logic [2:0]    w_new_err;
    logic [2:0]    w_sticky_nxt;
    logic [5:0]    w_actag_nxt;
    logic          w_unused_actag_hi;

    assign w_unused_actag_hi = ^afu_tlx_cmd_actag[11:6];

    // Input packing and stage-1 table lookup / error classification
    always_comb begin
        w_in_cmd           = '0;
        w_in_cmd.opcode    = afu_tlx_cmd_opcode;
        w_in_cmd.afutag    = afu_tlx_cmd_afutag;
        w_in_cmd.ea_or_obj = afu_tlx_cmd_ea_or_obj;
        w_in_cmd.dl        = afu_tlx_cmd_dl;
        w_in_cmd.pl        = afu_tlx_cmd_pl;
        w_in_cmd.pasid     = afu_tlx_cmd_pasid;
        w_in_cmd.actag     = afu_tlx_cmd_actag[5:0];

        w_is_assign = r_s1_valid && (r_s1_cmd.opcode == OP_ASSIGN);
        w_is_cmd    = r_s1_valid && (r_s1_cmd.opcode != OP_ASSIGN);
        w_ent_vld   = r_tbl_vld[r_s1_cmd.actag];
        w_ent_pasid = r_tbl_pasid[r_s1_cmd.actag];
        w_err       = {w_ent_vld && (w_ent_pasid != r_s1_cmd.pasid), !w_ent_vld};

        w_push_cmd     = r_s1_cmd;
        w_push_cmd.err = w_err;
    end

    // FIFO control, ready occupancy and sticky-error next state
    always_comb begin
        w_full = (r_count == FULL_CNT);
        w_pop  = (r_count != {CW{1'b0}}) && out_cmd_ready;
        w_push = w_is_cmd && (!w_full || w_pop);
        w_ovf  = w_is_cmd && w_full && !w_pop;
        w_occ  = (CW + 1)'(r_count) + (CW + 1)'(r_s1_valid) + (CW + 1)'(afu_tlx_cmd_valid);

        // A new error in the same cycle as err_clear survives the clear
        w_sticky_base = err_clear ? 3'b000 : r_err_sticky;
        w_new_err     = {w_ovf, (w_push ? w_err : 2'b00)};
        w_sticky_nxt  = w_sticky_base | w_new_err;
        if ((w_new_err != 3'b000) && (w_sticky_base == 3'b000)) begin
            w_actag_nxt = r_s1_cmd.actag;
        end else if (err_clear) begin
            w_actag_nxt = 6'd0;
        end else begin
            w_actag_nxt = r_err_actag;
        end
    end

    // Stage-1 capture; every strobe is taken unconditionally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cmd   <= '0;
        end else begin
            r_s1_valid <= afu_tlx_cmd_valid;
            r_s1_cmd   <= w_in_cmd;
        end
    end

    // Table valid bits; an assign is visible to the very next captured command
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tbl_vld <= 64'd0;
        end else if (w_is_assign) begin
            r_tbl_vld[r_s1_cmd.actag] <= 1'b1;
        end
    end

    // Table PASID storage
    always_ff @(posedge clk) begin
        if (w_is_assign) begin
            r_tbl_pasid[r_s1_cmd.actag] <= r_s1_cmd.pasid;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_cmd;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered ready and sticky error reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready      <= 1'b0;
            r_err_sticky <= 3'b000;
            r_err_actag  <= 6'd0;
        end else begin
            r_ready      <= (w_occ <= READY_LIM);
            r_err_sticky <= w_sticky_nxt;
            r_err_actag  <= w_actag_nxt;
        end
    end

    // Head fields are held at zero while the FIFO is empty
    always_comb begin
        if (r_count != {CW{1'b0}}) begin
            w_head = r_mem[r_rd_ptr];
        end else begin
            w_head = '0;
        end
    end

    assign tlx_afu_cmd_ready = r_ready;
    assign out_cmd_valid     = (r_count != {CW{1'b0}});
    assign out_cmd_opcode    = w_head.opcode;
    assign out_cmd_afutag    = w_head.afutag;
    assign out_cmd_ea_or_obj = w_head.ea_or_obj;
    assign out_cmd_dl        = w_head.dl;
    assign out_cmd_pl        = w_head.pl;
    assign out_cmd_pasid     = w_head.pasid;
    assign out_cmd_actag     = w_head.actag;
    assign out_cmd_err       = w_head.err;
    assign err_sticky        = r_err_sticky;
    assign err_actag         = r_err_actag;

endmodule

// File: tb/tb_brdg_context_receiver.sv
// Bench for brdg_context_receiver: directed scenarios plus randomized traffic checked
// against a send-order reference model (table array, expected-output queue, sticky state).
module tb_brdg_context_receiver;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        afu_tlx_cmd_valid = 1'b0;
    logic [7:0]  afu_tlx_cmd_opcode = 8'h00;
    logic [15:0] afu_tlx_cmd_afutag = 16'h0000;
    logic [67:0] afu_tlx_cmd_ea_or_obj = 68'h0;
    logic [1:0]  afu_tlx_cmd_dl = 2'b00;
    logic [2:0]  afu_tlx_cmd_pl = 3'b000;
    logic [11:0] afu_tlx_cmd_actag = 12'h000;
    logic [19:0] afu_tlx_cmd_pasid = 20'h00000;
    logic        tlx_afu_cmd_ready;
    logic        out_cmd_valid;
    logic        out_cmd_ready = 1'b0;
    logic [7:0]  out_cmd_opcode;
    logic [15:0] out_cmd_afutag;
    logic [67:0] out_cmd_ea_or_obj;
    logic [1:0]  out_cmd_dl;
    logic [2:0]  out_cmd_pl;
    logic [19:0] out_cmd_pasid;
    logic [5:0]  out_cmd_actag;
    logic [1:0]  out_cmd_err;
    logic        err_clear = 1'b0;
    logic [2:0]  err_sticky;
    logic [5:0]  err_actag;

    brdg_context_receiver #(.DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .afu_tlx_cmd_valid(afu_tlx_cmd_valid), .afu_tlx_cmd_opcode(afu_tlx_cmd_opcode),
        .afu_tlx_cmd_afutag(afu_tlx_cmd_afutag), .afu_tlx_cmd_ea_or_obj(afu_tlx_cmd_ea_or_obj),
        .afu_tlx_cmd_dl(afu_tlx_cmd_dl), .afu_tlx_cmd_pl(afu_tlx_cmd_pl),
        .afu_tlx_cmd_actag(afu_tlx_cmd_actag), .afu_tlx_cmd_pasid(afu_tlx_cmd_pasid),
        .tlx_afu_cmd_ready(tlx_afu_cmd_ready),
        .out_cmd_valid(out_cmd_valid), .out_cmd_ready(out_cmd_ready),
        .out_cmd_opcode(out_cmd_opcode), .out_cmd_afutag(out_cmd_afutag),
        .out_cmd_ea_or_obj(out_cmd_ea_or_obj), .out_cmd_dl(out_cmd_dl), .out_cmd_pl(out_cmd_pl),
        .out_cmd_pasid(out_cmd_pasid), .out_cmd_actag(out_cmd_actag), .out_cmd_err(out_cmd_err),
        .err_clear(err_clear), .err_sticky(err_sticky), .err_actag(err_actag)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [63:0]  m_vld;
    logic [19:0]  m_pasid [0:63];
    logic [124:0] exp_q [$];
    logic [2:0]   m_sticky, m_pend;
    logic [5:0]   m_actag, m_pend_at;

    logic last_rdy = 1'b0;
    logic g_ordy   = 1'b1;
    logic g_clr    = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_vld     = 64'd0;
        m_sticky  = 3'b000;
        m_actag   = 6'd0;
        m_pend    = 3'b000;
        m_pend_at = 6'd0;
    endtask

    // One clock cycle: drive at negedge, update the model, check any pop 1ns later
    task automatic cyc(input logic want, input logic [7:0] op, input logic [5:0] at,
                       input logic [19:0] pa, input logic force_drop, output logic sent);
        logic          ok;
        logic [1:0]    e;
        logic [15:0]   tag;
        logic [67:0]   ea;
        logic [1:0]    dl;
        logic [2:0]    pl;
        logic [124:0]  got;
        logic [124:0]  exp;
        @(negedge clk);
        ok       = last_rdy;
        last_rdy = tlx_afu_cmd_ready;
        sent     = want && (ok || force_drop);
        tag      = 16'($urandom);
        ea       = {4'($urandom), $urandom, $urandom};
        dl       = 2'($urandom);
        pl       = 3'($urandom);
        afu_tlx_cmd_valid     = sent;
        afu_tlx_cmd_opcode    = op;
        afu_tlx_cmd_afutag    = tag;
        afu_tlx_cmd_ea_or_obj = ea;
        afu_tlx_cmd_dl        = dl;
        afu_tlx_cmd_pl        = pl;
        afu_tlx_cmd_actag     = {6'($urandom), at};
        afu_tlx_cmd_pasid     = pa;
        out_cmd_ready         = g_ordy;
        err_clear             = g_clr;
        // Errors of last cycle's command land now; a clear in the same cycle loses to them
        if (g_clr) begin
            m_sticky = 3'b000;
            m_actag  = 6'd0;
        end
        if (m_pend != 3'b000) begin
            if (m_sticky == 3'b000) m_actag = m_pend_at;
            m_sticky = m_sticky | m_pend;
        end
        m_pend    = 3'b000;
        m_pend_at = at;
        if (sent) begin
            if (force_drop) begin
                m_pend = 3'b100;
            end else if (op == 8'h50) begin
                m_vld[at]   = 1'b1;
                m_pasid[at] = pa;
            end else begin
                e = !m_vld[at] ? 2'b01 : ((m_pasid[at] != pa) ? 2'b10 : 2'b00);
                m_pend = {1'b0, e};
                exp_q.push_back({op, tag, ea, dl, pl, pa, at, e});
            end
        end
        g_clr = 1'b0;
        #1;
        if (out_cmd_valid && out_cmd_ready) begin
            chk("pop_expected", 128'(exp_q.size() != 0), 128'(1'b1));
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                got = {out_cmd_opcode, out_cmd_afutag, out_cmd_ea_or_obj, out_cmd_dl, out_cmd_pl,
                       out_cmd_pasid, out_cmd_actag, out_cmd_err};
                chk("pop_cmd", 128'(got), 128'(exp));
            end
        end
    endtask

    task automatic idle(input int n);
        logic s;
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 6'd0, 20'd0, 1'b0, s);
    endtask

    task automatic send(input logic [7:0] op, input logic [5:0] at, input logic [19:0] pa);
        logic s;
        s = 1'b0;
        for (int i = 0; i < 50 && !s; i++) cyc(1'b1, op, at, pa, 1'b0, s);
        chk("send_accepted", 128'(s), 128'(1'b1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        afu_tlx_cmd_valid = 1'b0;
        err_clear = 1'b0;
        model_clear();
        @(negedge clk);
        #1;
        chk("rst_out_valid", 128'(out_cmd_valid), 128'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        last_rdy = tlx_afu_cmd_ready;
        #1;
        chk("rst_ready_first", 128'(tlx_afu_cmd_ready), 128'(1'b0));
        chk("rst_sticky", 128'(err_sticky), 128'(3'b000));
        chk("rst_err_actag", 128'(err_actag), 128'(6'd0));
    endtask

    initial begin
        int   nsent;
        logic s;
        logic [7:0] op;
        logic [5:0] at;
        model_clear();
        do_reset();
        idle(1);
        chk("ready_second", 128'(tlx_afu_cmd_ready), 128'(1'b1));

        // Assign then DMA write next cycle; output appears two cycles after its valid
        g_ordy = 1'b1;
        send(8'h50, 6'd5, 20'h00123);
        send(8'h20, 6'd5, 20'h00123);
        idle(1);
        chk("lat_n1", 128'(out_cmd_valid), 128'(1'b0));
        idle(1);
        chk("lat_n2", 128'(out_cmd_valid), 128'(1'b1));
        idle(2);
        chk("dma_ok_sticky", 128'(err_sticky), 128'(3'b000));

        // Unassigned acTag
        send(8'h10, 6'd9, 20'h00055);
        idle(4);
        chk("unassigned_sticky", 128'(err_sticky), 128'(3'b001));
        chk("unassigned_actag", 128'(err_actag), 128'(6'd9));

        // PASID mismatch, then rebinding clears it
        g_clr = 1'b1;
        idle(1);
        send(8'h50, 6'd5, 20'h00040);
        send(8'h20, 6'd5, 20'h00041);
        send(8'h50, 6'd5, 20'h00041);
        send(8'h20, 6'd5, 20'h00041);
        idle(4);
        chk("mismatch_sticky", 128'(err_sticky), 128'(3'b010));
        chk("mismatch_actag", 128'(err_actag), 128'(6'd5));

        // Fill with downstream stalled, then force one past the ready rule
        g_clr = 1'b1;
        g_ordy = 1'b0;
        idle(1);
        nsent = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'h20, 6'd5, 20'h00041, 1'b0, s);
            nsent += int'(s);
        end
        chk("fill_count", 128'(nsent), 128'(DEPTH));
        chk("fill_ready_low", 128'(tlx_afu_cmd_ready), 128'(1'b0));
        chk("fill_no_ovf", 128'(err_sticky), 128'(3'b000));
        cyc(1'b1, 8'h20, 6'd5, 20'h00041, 1'b1, s);
        idle(2);
        chk("ovf_sticky", 128'(err_sticky), 128'(3'b100));
        chk("ovf_actag", 128'(err_actag), 128'(6'd5));
        g_ordy = 1'b1;
        idle(12);
        chk("drained", 128'(exp_q.size()), 128'(0));
        chk("drained_valid", 128'(out_cmd_valid), 128'(1'b0));

        // Clear coincident with a new unassigned error: the error wins
        send(8'h10, 6'd33, 20'h00007);
        g_clr = 1'b1;
        idle(3);
        chk("clr_vs_err_sticky", 128'(err_sticky), 128'(3'b001));
        chk("clr_vs_err_actag", 128'(err_actag), 128'(6'd33));

        // Reset with commands queued and the table populated
        g_ordy = 1'b0;
        send(8'h20, 6'd5, 20'h00041);
        send(8'h20, 6'd5, 20'h00041);
        send(8'h20, 6'd5, 20'h00041);
        idle(2);
        chk("pre_rst_valid", 128'(out_cmd_valid), 128'(1'b1));
        do_reset();
        g_ordy = 1'b1;
        send(8'h20, 6'd5, 20'h00041);
        idle(4);
        chk("post_rst_sticky", 128'(err_sticky), 128'(3'b001));

        // Randomized traffic against the model
        g_clr = 1'b1;
        idle(1);
        for (int i = 0; i < 400; i++) begin
            case ($urandom % 4)
                0:       op = 8'h50;
                1:       op = 8'h20;
                2:       op = 8'h10;
                default: op = 8'h21;
            endcase
            at = (($urandom % 8) == 0) ? 6'($urandom) : 6'($urandom % 6);
            g_ordy = (($urandom % 4) != 0);
            cyc(($urandom % 4) != 0, op, at, 20'(($urandom % 3) + 32'h40), 1'b0, s);
        end
        g_ordy = 1'b1;
        idle(20);
        chk("rand_drained", 128'(exp_q.size()), 128'(0));
        chk("rand_sticky", 128'(err_sticky), 128'(m_sticky));
        chk("rand_err_actag", 128'(err_actag), 128'(m_actag));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
